reg_status_file: RTL and testbench

- Architectural register file plus rename-status table. Sits directly downstream of the reorder buffer's issue/commit outputs and upstream of the reservation stations and load/store buffer operand fetch.
- On issue, it records which RoB entry will produce each destination register.
- On commit, it writes the retired value and clears the rename tag when the tag still matches.
- It serves two combinational operand lookups with same-cycle commit bypass, and drops all rename tags on a mispredict clear.

---
 rtl/reg_status_file_if.sv | 34 +++
 rtl/reg_status_file.sv | 63 ++++++
 tb/tb_reg_status_file.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: issue, commit and operand-lookup signals of the register status file
interface reg_status_file_if #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4,
  parameter int AW       = 5
);
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [ROB_ID_W-1:0] issue_rob_id;
  logic                commit_valid;
  logic [AW-1:0]       commit_rd;
  logic [ROB_ID_W-1:0] commit_rob_id;
  logic [XLEN-1:0]     commit_value;
  logic [AW-1:0]       rs1_idx;
  logic [AW-1:0]       rs2_idx;
  logic [XLEN-1:0]     rs1_value;
  logic [XLEN-1:0]     rs2_value;
  logic                rs1_busy;
  logic                rs2_busy;
  logic [ROB_ID_W-1:0] rs1_rob_id;
  logic [ROB_ID_W-1:0] rs2_rob_id;
  modport master (
    output issue_valid, issue_rd, issue_rob_id,
    output commit_valid, commit_rd, commit_rob_id, commit_value,
    output rs1_idx, rs2_idx,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_rob_id, rs2_rob_id
  );
  modport slave (
    input  issue_valid, issue_rd, issue_rob_id,
    input  commit_valid, commit_rd, commit_rob_id, commit_value,
    input  rs1_idx, rs2_idx,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_rob_id, rs2_rob_id
  );
endinterface

// File: rtl/reg_status_file.sv
// reg_status_file: architectural registers plus rename tags with commit bypass on two lookup ports
module reg_status_file #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  reg_status_file_if.slave b
);
  localparam int AW = $clog2(REG_NUM);
  logic [XLEN-1:0]     value_q [REG_NUM];
  logic [ROB_ID_W-1:0] tag_q   [REG_NUM];
  logic [REG_NUM-1:0]  busy_q;
  logic                commit_hit;
  logic [AW-1:0]       idx [2];
  logic [XLEN-1:0]     rv  [2];
  logic                rb  [2];
  logic [ROB_ID_W-1:0] rt  [2];
  assign commit_hit = b.commit_valid && b.commit_rd != '0 && busy_q[b.commit_rd] &&
                      tag_q[b.commit_rd] == b.commit_rob_id;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (b.commit_valid && b.commit_rd != '0) value_q[b.commit_rd] <= b.commit_value;
      if (clear) begin
        busy_q <= '0;
        for (int i = 0; i < REG_NUM; i++) tag_q[i] <= '0;
      end else begin
        if (commit_hit) begin
          busy_q[b.commit_rd] <= 1'b0;
          tag_q[b.commit_rd]  <= '0;
        end
        // issue is applied last so it overrides a same-register commit
        if (b.issue_valid && b.issue_rd != '0) begin
          busy_q[b.issue_rd] <= 1'b1;
          tag_q[b.issue_rd]  <= b.issue_rob_id;
        end
      end
    end
  assign idx[0] = b.rs1_idx;
  assign idx[1] = b.rs2_idx;
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic byp;
    assign byp   = commit_hit && !clear && b.commit_rd == idx[p];
    assign rv[p] = idx[p] == '0 ? '0 : byp ? b.commit_value : value_q[idx[p]];
    assign rb[p] = idx[p] != '0 && busy_q[idx[p]] && !byp;
    assign rt[p] = rb[p] ? tag_q[idx[p]] : '0;
  end
  assign b.rs1_value  = rv[0];
  assign b.rs2_value  = rv[1];
  assign b.rs1_busy   = rb[0];
  assign b.rs2_busy   = rb[1];
  assign b.rs1_rob_id = rt[0];
  assign b.rs2_rob_id = rt[1];
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed vectors against hand-computed register/rename state
module tb_reg_status_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  reg_status_file_if b ();
  reg_status_file dut (.clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .b(b));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic look(string tag, logic [4:0] idx, logic [31:0] v, logic bz, logic [3:0] id);
    b.rs1_idx = idx;
    b.rs2_idx = idx;
    #1;
    check({tag, ".v1"}, b.rs1_value, v);
    check({tag, ".b1"}, {31'd0, b.rs1_busy}, {31'd0, bz});
    check({tag, ".t1"}, {28'd0, b.rs1_rob_id}, {28'd0, id});
    check({tag, ".v2"}, b.rs2_value, v);
    check({tag, ".b2"}, {31'd0, b.rs2_busy}, {31'd0, bz});
    check({tag, ".t2"}, {28'd0, b.rs2_rob_id}, {28'd0, id});
  endtask
  task automatic idle();
    b.issue_valid = 1'b0;
    b.issue_rd = '0;
    b.issue_rob_id = '0;
    b.commit_valid = 1'b0;
    b.commit_rd = '0;
    b.commit_rob_id = '0;
    b.commit_value = '0;
    clear = 1'b0;
  endtask
  task automatic issue(logic [4:0] rd, logic [3:0] id);
    b.issue_valid = 1'b1;
    b.issue_rd = rd;
    b.issue_rob_id = id;
  endtask
  task automatic commit(logic [4:0] rd, logic [3:0] id, logic [31:0] v);
    b.commit_valid = 1'b1;
    b.commit_rd = rd;
    b.commit_rob_id = id;
    b.commit_value = v;
  endtask
  task automatic step();
    @(negedge clk);
    idle();
  endtask
  initial begin
    idle();
    b.rs1_idx = '0;
    b.rs2_idx = '0;
    @(negedge clk);
    look("rst_hold", 5'd5, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    commit(5'd5, 4'd0, 32'h1234);
    issue(5'd5, 4'd1);
    step();
    look("x5_set", 5'd5, 32'h1234, 1'b1, 4'd1);
    rst = 1'b0;
    look("rst_async", 5'd5, 32'h0, 1'b0, 4'd0);
    step();
    rst = 1'b1;
    look("rst_after", 5'd5, 32'h0, 1'b0, 4'd0);
    issue(5'd3, 4'd7);
    step();
    look("x3_busy", 5'd3, 32'h0, 1'b1, 4'd7);
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    look("x3_byp", 5'd3, 32'hDEADBEEF, 1'b0, 4'd0);
    step();
    look("x3_state", 5'd3, 32'hDEADBEEF, 1'b0, 4'd0);
    issue(5'd4, 4'd2);
    step();
    issue(5'd4, 4'd5);
    step();
    commit(5'd4, 4'd2, 32'h11);
    look("x4_nobyp", 5'd4, 32'h0, 1'b1, 4'd5);
    step();
    look("x4_stale", 5'd4, 32'h11, 1'b1, 4'd5);
    issue(5'd6, 4'd1);
    step();
    issue(5'd6, 4'd9);
    commit(5'd6, 4'd1, 32'h22);
    look("x6_byp", 5'd6, 32'h22, 1'b0, 4'd0);
    step();
    look("x6_both", 5'd6, 32'h22, 1'b1, 4'd9);
    issue(5'd8, 4'd3);
    step();
    issue(5'd9, 4'd4);
    step();
    commit(5'd8, 4'd3, 32'h55);
    issue(5'd10, 4'd6);
    clear = 1'b1;
    look("x8_clr_pre", 5'd8, 32'h0, 1'b1, 4'd3);
    step();
    look("x8_clr", 5'd8, 32'h55, 1'b0, 4'd0);
    look("x9_clr", 5'd9, 32'h0, 1'b0, 4'd0);
    look("x10_clr", 5'd10, 32'h0, 1'b0, 4'd0);
    look("x4_clr", 5'd4, 32'h11, 1'b0, 4'd0);
    issue(5'd0, 4'd3);
    commit(5'd0, 4'd0, 32'hFF);
    step();
    look("x0", 5'd0, 32'h0, 1'b0, 4'd0);
    rdy = 1'b0;
    issue(5'd2, 4'd5);
    commit(5'd2, 4'd1, 32'h77);
    step();
    look("rdy_hold", 5'd2, 32'h0, 1'b0, 4'd0);
    issue(5'd11, 4'd2);
    step();
    rdy = 1'b1;
    commit(5'd11, 4'd2, 32'h99);
    look("rdy_nobyp", 5'd11, 32'h0, 1'b0, 4'd0);
    step();
    look("x11_val", 5'd11, 32'h99, 1'b0, 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
